hdlc_bit_stuffer: RTL

//  Streaming HDLC framer/bit stuffer for the RS-485 transmit path: accepts parallel words, emits a serial
//  MSB-first bitstream with opening/closing flags and a zero inserted after every RUN_LEN consecutive ones.
//  The run counter carries across word boundaries within a frame. Sits between the frame builder and the UART/line driver.

---
 rtl/hdlc_pkg.sv | 19 +
 rtl/hdlc_word_hold.sv | 33 +++
 rtl/hdlc_bit_stuffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// Shared constants for the HDLC transmit framer: defaults, flag pattern and FSM encodings.
package hdlc_pkg;

  localparam int unsigned HDLC_DATA_W  = 8;
  localparam int unsigned HDLC_RUN_LEN = 5;
  localparam logic [7:0]  HDLC_FLAG    = 8'h7E;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPEN  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STUFF = 3'd3;
  localparam logic [2:0] ST_CLOSE = 3'd4;

  // Flag bits go out MSB first; pos 0 is the first bit on the line.
  function automatic logic flag_bit(input logic [7:0] flag, input logic [2:0] pos);
    return flag[3'd7 - pos];
  endfunction

endpackage

// File: rtl/hdlc_word_hold.sv
// One-word holding register between the frame builder and the bit shifter.
module hdlc_word_hold #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_last,
  output logic              hold_vld
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_vld  <= 1'b0;
    end else if (in_valid && !hold_vld) begin
      hold_data <= in_data;
      hold_last <= in_last;
      hold_vld  <= 1'b1;
    end else if (pop) begin
      hold_vld  <= 1'b0;
    end
  end

  assign in_ready = !hold_vld;

endmodule

// File: rtl/hdlc_bit_stuffer.sv
// HDLC transmit framer: serialises words MSB first between flags, inserting a zero after RUN_LEN ones.
module hdlc_bit_stuffer
  import hdlc_pkg::*;
#(
  parameter int unsigned DATA_W  = HDLC_DATA_W,
  parameter int unsigned RUN_LEN = HDLC_RUN_LEN,
  parameter logic [7:0]  FLAG    = HDLC_FLAG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_flag,
  output logic              out_stuff,
  output logic              busy
);

  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_vld;
  logic              pop;

  hdlc_word_hold #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .pop       (pop),
    .hold_data (hold_data),
    .hold_last (hold_last),
    .hold_vld  (hold_vld)
  );

  logic [2:0]        state, state_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]  bits_left, bits_left_nxt;
  logic              shift_last, shift_last_nxt;
  logic [2:0]        flag_idx, flag_idx_nxt;
  logic [RUN_W-1:0]  run, run_nxt;
  logic              bit_nxt, valid_nxt, flag_nxt, stuff_nxt, busy_nxt;
  logic              advance, load, emit_data, hold_vld_nxt;
  logic [DATA_W-1:0] src;

  // The output register is refilled when empty or when its bit is taken.
  assign advance      = !out_valid || out_ready;
  assign hold_vld_nxt = (hold_vld && !pop) || (in_valid && !hold_vld);
  assign busy_nxt     = (state_nxt != ST_IDLE) || hold_vld_nxt;

  // Next-bit selection: state names the kind of bit currently presented.
  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift;
    bits_left_nxt  = bits_left;
    shift_last_nxt = shift_last;
    flag_idx_nxt   = flag_idx;
    run_nxt        = run;
    bit_nxt        = out_bit;
    valid_nxt      = out_valid;
    flag_nxt       = out_flag;
    stuff_nxt      = out_stuff;
    load           = 1'b0;
    emit_data      = 1'b0;
    pop            = 1'b0;
    src            = shift;

    if (advance) begin
      bit_nxt   = 1'b0;
      valid_nxt = 1'b0;
      flag_nxt  = 1'b0;
      stuff_nxt = 1'b0;
      case (state)
        ST_IDLE: begin
          if (hold_vld) begin
            state_nxt    = ST_OPEN;
            flag_idx_nxt = 3'd0;
            run_nxt      = '0;
            valid_nxt    = 1'b1;
            flag_nxt     = 1'b1;
            bit_nxt      = flag_bit(FLAG, 3'd0);
          end
        end
        ST_OPEN: begin
          if (flag_idx != 3'd7) begin
            flag_idx_nxt = flag_idx + 3'd1;
            valid_nxt    = 1'b1;
            flag_nxt     = 1'b1;
            bit_nxt      = flag_bit(FLAG, flag_idx + 3'd1);
          end else begin
            load      = 1'b1;
            emit_data = 1'b1;
          end
        end
        ST_DATA, ST_STUFF: begin
          if (run == RUN_W'(RUN_LEN)) begin
            state_nxt = ST_STUFF;
            run_nxt   = '0;
            valid_nxt = 1'b1;
            stuff_nxt = 1'b1;
          end else if (bits_left != '0) begin
            emit_data = 1'b1;
          end else if (shift_last) begin
            state_nxt    = ST_CLOSE;
            flag_idx_nxt = 3'd0;
            valid_nxt    = 1'b1;
            flag_nxt     = 1'b1;
            bit_nxt      = flag_bit(FLAG, 3'd0);
          end else if (hold_vld) begin
            load      = 1'b1;
            emit_data = 1'b1;
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_CLOSE: begin
          if (flag_idx != 3'd7) begin
            flag_idx_nxt = flag_idx + 3'd1;
            valid_nxt    = 1'b1;
            flag_nxt     = 1'b1;
            bit_nxt      = flag_bit(FLAG, flag_idx + 3'd1);
          end else if (hold_vld) begin
            state_nxt    = ST_OPEN;
            flag_idx_nxt = 3'd0;
            run_nxt      = '0;
            valid_nxt    = 1'b1;
            flag_nxt     = 1'b1;
            bit_nxt      = flag_bit(FLAG, 3'd0);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      if (emit_data) begin
        src            = load ? hold_data : shift;
        pop            = load;
        state_nxt      = ST_DATA;
        valid_nxt      = 1'b1;
        bit_nxt        = src[DATA_W-1];
        shift_nxt      = {src[DATA_W-2:0], 1'b0};
        bits_left_nxt  = load ? IDX_W'(DATA_W - 1) : bits_left - IDX_W'(1);
        shift_last_nxt = load ? hold_last : shift_last;
        run_nxt        = src[DATA_W-1] ? run + RUN_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bits_left  <= '0;
      shift_last <= 1'b0;
      flag_idx   <= 3'd0;
      run        <= '0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      out_flag   <= 1'b0;
      out_stuff  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bits_left  <= bits_left_nxt;
      shift_last <= shift_last_nxt;
      flag_idx   <= flag_idx_nxt;
      run        <= run_nxt;
      out_bit    <= bit_nxt;
      out_valid  <= valid_nxt;
      out_flag   <= flag_nxt;
      out_stuff  <= stuff_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
